ahbl_apb_bridge: RTL and testbench
==================================

Name: ahbl_apb_bridge

Overview:
- AHB-Lite slave to APB3 master bridge; one slave port of the 3-way AHB-Lite splitter, typically on the 0x4 peripheral region.
- Consumes the splitter's HSEL and the shared HREADY; returns HREADYOUT, HRDATA and HRESP to the splitter's mux.
- Converts each selected NONSEQ/SEQ transfer into one APB SETUP+ACCESS transaction, inserting AHB wait states until PREADY.
- Maps PSLVERR to a two-cycle AHB ERROR response.

Parameters:
- PADDR_W, 16, APB address width; PADDR = latched HADDR[PADDR_W-1:0].
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced error (used only with the optional feature).

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select from splitter decoder
- HADDR  in  32  AHB address
- HTRANS  in  2  AHB transfer type
- HWRITE  in  1  write/read
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-level ready from splitter mux
- HREADYOUT  out  1  this slave's ready
- HRDATA  out  32  read data
- HRESP  out  1  0=OKAY, 1=ERROR
- PADDR  out  PADDR_W  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB byte strobes
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Transfer start: an address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register HADDR[PADDR_W-1:0], HWRITE and the strobe pattern.
- Strobes, writes only (reads give PSTRB=0):
  - HSIZE=0: 1<<HADDR[1:0]
  - HSIZE=1: 4'b0011<<{HADDR[1],1'b0}
  - HSIZE>=2: 4'hF
- States:
  - IDLE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Accepted transfer -> SETUP. HSEL with IDLE/BUSY HTRANS: zero-wait OKAY, stay in IDLE.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Always -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=0: stay, HREADYOUT=0.
    - PREADY=1 & PSLVERR=0: HREADYOUT=1 this cycle. Next state is SETUP if a new transfer is accepted this cycle, else IDLE.
    - PREADY=1 & PSLVERR=1: HREADYOUT=0, -> ERR1.
  - ERR1: PSEL=0, HREADYOUT=0, HRESP=1. -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state is SETUP if a transfer is accepted, else IDLE.
- Data:
  - PWDATA = HWDATA, passed through combinationally. It is valid because the AHB data phase is held through SETUP/ACCESS while HREADYOUT=0.
  - HRDATA = PRDATA, passed through combinationally. Valid in the ACCESS cycle with PREADY=1.
- Latency: minimum data phase is 2 HCLK (SETUP, ACCESS with PREADY=1); each PREADY=0 cycle adds 1.
- Back-to-back: no idle cycle is inserted between APB transactions when the next address phase coincides with completion.
- HSEL low, or the other slave selected, during an outstanding transfer: has no effect; the transaction completes.
- Reset values, asynchronously on HRESETn=0 including mid-transaction: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PSTRB=0, HREADYOUT=1, HRESP=0.

Optional Feature:
- Macro AHBL_APB_BRIDGE_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. On reaching TIMEOUT_CYCLES, drop PSEL/PENABLE and go to ERR1; late PREADY is ignored.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package (ahbl_pkg): HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HSIZE codes, HRESP codes, bridge state encoding.
- One natural sub-module: apb_strb_gen (combinational HSIZE/HADDR[1:0]/HWRITE -> PSTRB).

Test Plan:
- Word write 0x4000_0010 <- 0xDEADBEEF, PREADY=1 immediately -> PADDR=0x0010, PSTRB=F, PWRITE=1; HREADYOUT low exactly 1 cycle (SETUP), OKAY.
- Read 0x4000_0004, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> HREADYOUT low 4 cycles, HRDATA=0x12345678 on completion.
- Byte write at HADDR[1:0]=2 -> PSTRB=4'b0100; halfword write at offset 2 -> PSTRB=4'b1100; read -> PSTRB=0.
- PSLVERR=1 with PREADY=1 -> HRESP=1, HREADYOUT=0 for 1 cycle then 1; next transfer starts cleanly.
- Back-to-back NONSEQ write then read -> second SETUP immediately follows first ACCESS; no IDLE cycle.
- HRESETn asserted during ACCESS -> PSEL/PENABLE 0 immediately, HREADYOUT=1. With TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck 0 -> ERROR after 4 ACCESS cycles.

Source files
------------

// File: rtl/ahbl_pkg.sv
`timescale 1ns / 1ps
// Shared AHB-Lite definitions for the AHB-Lite to APB3 bridge.
// Contents: HTRANS, HSIZE and HRESP codes, and the bridge state encoding.
package ahbl_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HsizeByte = 3'b000;
  localparam logic [2:0] HsizeHalf = 3'b001;
  localparam logic [2:0] HsizeWord = 3'b010;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } bridge_state_e;

endpackage

// File: rtl/apb_strb_gen.sv
`timescale 1ns / 1ps
// APB byte-strobe generator.
// Ports:
//   hsize   - AHB transfer size
//   addr_lo - HADDR[1:0] of the transfer
//   hwrite  - 1 for writes; reads always produce a zero strobe
//   strb    - APB PSTRB pattern
module apb_strb_gen
  import ahbl_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       hwrite,
  output logic [3:0] strb
);

  always_comb begin
    strb = 4'h0;
    if (hwrite) begin
      if (hsize == HsizeByte) begin
        strb = 4'b0001 << addr_lo;
      end else if (hsize == HsizeHalf) begin
        strb = 4'b0011 << {addr_lo[1], 1'b0};
      end else begin
        // Word and anything wider covers the whole 32-bit lane.
        strb = 4'hF;
      end
    end
  end

endmodule

// File: rtl/ahbl_apb_bridge.sv
`timescale 1ns / 1ps
// AHB-Lite slave to APB3 master bridge.
// Each accepted NONSEQ/SEQ transfer becomes one APB SETUP+ACCESS transaction; AHB wait
// states are inserted until PREADY. PSLVERR becomes a two-cycle AHB ERROR response.
// Optional build macro: AHBL_APB_BRIDGE_TIMEOUT_EN adds an ACCESS watchdog that forces an
// ERROR after TIMEOUT_CYCLES cycles of PREADY low.
// Ports:
//   HCLK, HRESETn                  - clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE,
//   HSIZE, HWDATA, HREADY          - AHB-Lite slave inputs
//   HREADYOUT, HRDATA, HRESP       - AHB-Lite slave outputs
//   PADDR, PSEL, PENABLE, PWRITE,
//   PWDATA, PSTRB                  - APB3 master outputs
//   PRDATA, PREADY, PSLVERR        - APB3 master inputs
module ahbl_apb_bridge
  import ahbl_pkg::*;
#(
  parameter int unsigned PADDR_W        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [31:0]        HRDATA,
  output logic               HRESP,
  output logic [PADDR_W-1:0] PADDR,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PWDATA,
  output logic [3:0]         PSTRB,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  bridge_state_e      state_q;
  logic               psel_q, penable_q, pwrite_q, hready_q, hresp_q;
  logic [PADDR_W-1:0] paddr_q;
  logic [3:0]         pstrb_q;
  logic [3:0]         strb_d;
  logic               accept, start, access_ok, access_err, timeout;

  assign accept = HSEL & HREADY & ((HTRANS == HtransNonseq) | (HTRANS == HtransSeq));

  assign access_ok  = (state_q == StAccess) & PREADY & ~PSLVERR;
  assign access_err = (state_q == StAccess) & PREADY & PSLVERR;

  // A new transfer can only be taken while this slave is presenting HREADYOUT=1.
  assign start = accept & ((state_q == StIdle) | (state_q == StErr2) | access_ok);

  apb_strb_gen u_strb_gen (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .hwrite  (HWRITE),
    .strb    (strb_d)
  );

`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  // Fires on the TIMEOUT_CYCLES-th stalled ACCESS cycle.
  assign timeout = (state_q == StAccess) & ~PREADY &
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (state_q == StSetup) begin
      cnt_q <= '0;
    end else if ((state_q == StAccess) && !PREADY) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cycles;

  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  logic unused_haddr;
  assign unused_haddr = ^HADDR[31:PADDR_W];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pstrb_q   <= 4'h0;
      hready_q  <= 1'b1;
      hresp_q   <= HrespOkay;
    end else begin
      unique case (state_q)
        StIdle: begin
          hready_q <= 1'b1;
          hresp_q  <= HrespOkay;
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          if (access_ok) begin
            state_q   <= StIdle;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
          end else if (access_err || timeout) begin
            state_q   <= StErr1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            hready_q  <= 1'b0;
            hresp_q   <= HrespError;
          end
        end
        StErr1: begin
          state_q  <= StErr2;
          hready_q <= 1'b1;
        end
        StErr2: begin
          state_q <= StIdle;
          hresp_q <= HrespOkay;
        end
        default: begin
          state_q   <= StIdle;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          hready_q  <= 1'b1;
          hresp_q   <= HrespOkay;
        end
      endcase

      // Acceptance overrides the completion path so back-to-back transfers skip IDLE.
      if (start) begin
        state_q   <= StSetup;
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        hready_q  <= 1'b0;
        hresp_q   <= HrespOkay;
        paddr_q   <= HADDR[PADDR_W-1:0];
        pwrite_q  <= HWRITE;
        pstrb_q   <= strb_d;
      end
    end
  end

  // Completion in ACCESS is reported in the same cycle PREADY arrives.
  assign HREADYOUT = (state_q == StAccess) ? access_ok : hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = PRDATA;
  assign PWDATA    = HWDATA;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
`timescale 1ns / 1ps
module tb_ahbl_apb_bridge;
  import ahbl_pkg::*;

`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned To = 4;
`else
  localparam int unsigned To = 255;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [15:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  always #5 HCLK = ~HCLK;

  // The bench acts as the splitter mux with this bridge as the only responder.
  assign HREADY = HREADYOUT;

  ahbl_apb_bridge #(
    .PADDR_W        (16),
    .TIMEOUT_CYCLES (To)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
  } xfer_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference strobe rule: byte lane = address offset, halfword = aligned lane pair.
  function automatic logic [3:0] exp_strb(input xfer_t x);
    int off;
    int s;
    off = int'(x.addr % 4);
    if (!x.write) return 4'd0;
    if (x.size == 3'd0) begin
      s = 1 << off;
    end else if (x.size == 3'd1) begin
      s = 3 << ((off / 2) * 2);
    end else begin
      s = 15;
    end
    return 4'(s);
  endfunction

  function automatic xfer_t mk(input logic [31:0] addr, input logic write, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int waits, input logic err);
    xfer_t x;
    x.addr = addr; x.write = write; x.size = size; x.wdata = wdata;
    x.rdata = rdata; x.waits = waits; x.err = err;
    return x;
  endfunction

  function automatic xfer_t rand_xfer();
    return mk({16'h4000, 16'($urandom)}, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
              $urandom, $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
  endfunction

  task automatic issue_addr(input xfer_t x);
    HSEL   = 1'b1;
    HTRANS = $urandom_range(0, 1) ? HtransNonseq : HtransSeq;
    HADDR  = x.addr;
    HWRITE = x.write;
    HSIZE  = x.size;
  endtask

  task automatic go_idle();
    // HSEL level during an outstanding transfer must not matter.
    HSEL   = 1'($urandom_range(0, 1));
    HTRANS = HtransIdle;
    HADDR  = $urandom;
    HWRITE = 1'($urandom_range(0, 1));
    HSIZE  = 3'($urandom_range(0, 3));
  endtask

  // Entered at posedge+1 right after x's address phase was accepted (DUT in SETUP).
  // If next_valid, nx's address phase is presented in x's completion cycle and the task
  // returns at posedge+1 with nx already in SETUP.
  task automatic run_data(input xfer_t x, input logic next_valid, input xfer_t nx);
    int   low;
    logic last;
    low     = 0;
    HWDATA  = x.wdata;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    go_idle();
    @(negedge HCLK);
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_paddr", 32'(PADDR), x.addr % 65536);
    chk("setup_pwrite", 32'(PWRITE), 32'(x.write));
    chk("setup_pstrb", 32'(PSTRB), 32'(exp_strb(x)));
    if (HREADYOUT !== 1'b1) low++;
    for (int i = 0; i <= x.waits; i++) begin
      @(posedge HCLK); #1;
      last    = (i == x.waits);
      PREADY  = last;
      PSLVERR = last & x.err;
      PRDATA  = last ? x.rdata : $urandom;
      if (last && !x.err && next_valid) issue_addr(nx);
      @(negedge HCLK);
      chk("access_psel", 32'(PSEL), 32'd1);
      chk("access_penable", 32'(PENABLE), 32'd1);
      chk("access_hreadyout", 32'(HREADYOUT), 32'(last && !x.err));
      chk("access_hresp", 32'(HRESP), 32'd0);
      if (HREADYOUT !== 1'b1) low++;
      if (x.write) chk("pwdata", PWDATA, x.wdata);
      if (last && !x.write && !x.err) chk("hrdata", HRDATA, x.rdata);
    end
    if (x.err) begin
      @(posedge HCLK); #1;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      @(negedge HCLK);
      chk("err1_hreadyout", 32'(HREADYOUT), 32'd0);
      chk("err1_hresp", 32'(HRESP), 32'd1);
      chk("err1_psel", 32'(PSEL), 32'd0);
      if (HREADYOUT !== 1'b1) low++;
      @(posedge HCLK); #1;
      if (next_valid) issue_addr(nx);
      @(negedge HCLK);
      chk("err2_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("err2_hresp", 32'(HRESP), 32'd1);
    end
    chk("wait_cycles", 32'(low), 32'(x.err ? x.waits + 3 : x.waits + 1));
    @(posedge HCLK); #1;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    if (!next_valid) begin
      @(negedge HCLK);
      chk("idle_psel", 32'(PSEL), 32'd0);
      chk("idle_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("idle_hresp", 32'(HRESP), 32'd0);
    end
  endtask

  task automatic single(input xfer_t x);
    xfer_t dummy;
    dummy = x;
    issue_addr(x);
    @(posedge HCLK); #1;
    run_data(x, 1'b0, dummy);
  endtask

  xfer_t x, nx;
  logic  chain;

  initial begin
    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = '0; HTRANS = HtransIdle; HWRITE = 1'b0; HSIZE = HsizeWord;
    HWDATA = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pstrb", 32'(PSTRB), 32'd0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Word write, zero wait.
    single(mk(32'h4000_0010, 1'b1, HsizeWord, 32'hDEAD_BEEF, 32'h0, 0, 1'b0));
    // Read with three stalled ACCESS cycles.
    single(mk(32'h4000_0004, 1'b0, HsizeWord, 32'h0, 32'h1234_5678, 3, 1'b0));
    // Byte / halfword / read strobes.
    single(mk(32'h4000_0022, 1'b1, HsizeByte, 32'h00AA_0000, 32'h0, 0, 1'b0));
    single(mk(32'h4000_0032, 1'b1, HsizeHalf, 32'hBBBB_0000, 32'h0, 1, 1'b0));
    single(mk(32'h4000_0040, 1'b0, HsizeByte, 32'h0, 32'hCAFE_F00D, 0, 1'b0));
    // Slave error followed by a clean transfer.
    single(mk(32'h4000_0050, 1'b1, HsizeWord, 32'h1111_2222, 32'h0, 0, 1'b1));
    single(mk(32'h4000_0054, 1'b0, HsizeWord, 32'h0, 32'h3333_4444, 0, 1'b0));

    // Back-to-back write then read: second SETUP directly after first ACCESS.
    x  = mk(32'h4000_0100, 1'b1, HsizeWord, 32'h5555_6666, 32'h0, 0, 1'b0);
    nx = mk(32'h4000_0104, 1'b0, HsizeWord, 32'h0, 32'h7777_8888, 2, 1'b0);
    issue_addr(x);
    @(posedge HCLK); #1;
    run_data(x, 1'b1, nx);
    run_data(nx, 1'b0, nx);

    // HSEL with IDLE/BUSY: zero-wait OKAY, no APB activity.
    for (int i = 0; i < 2; i++) begin
      HSEL   = 1'b1;
      HTRANS = (i == 0) ? HtransBusy : HtransIdle;
      HADDR  = 32'h4000_0200;
      @(posedge HCLK);
      @(negedge HCLK);
      chk("nop_psel", 32'(PSEL), 32'd0);
      chk("nop_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("nop_hresp", 32'(HRESP), 32'd0);
    end

    // Randomised run with random chaining and error injection.
    x = rand_xfer();
    issue_addr(x);
    @(posedge HCLK); #1;
    for (int k = 0; k < 40; k++) begin
      chain = (k < 39) && ($urandom_range(0, 1) == 1);
      nx = rand_xfer();
      run_data(x, chain, nx);
      if (!chain && k < 39) begin
        issue_addr(nx);
        @(posedge HCLK); #1;
      end
      x = nx;
    end

    // Reset asserted in the middle of ACCESS.
    x = mk(32'h4000_ABCE, 1'b1, HsizeByte, 32'h0, 32'h0, 5, 1'b0);
    issue_addr(x);
    @(posedge HCLK); #1;
    go_idle();
    PREADY = 1'b0;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("pre_rst_penable", 32'(PENABLE), 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_psel", 32'(PSEL), 32'd0);
    chk("midrst_penable", 32'(PENABLE), 32'd0);
    chk("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("midrst_paddr", 32'(PADDR), 32'd0);
    chk("midrst_pstrb", 32'(PSTRB), 32'd0);
    chk("midrst_pwrite", 32'(PWRITE), 32'd0);
    chk("midrst_hresp", 32'(HRESP), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    HTRANS  = HtransIdle;
    single(mk(32'h4000_0300, 1'b1, HsizeHalf, 32'h9999_AAAA, 32'h0, 0, 1'b0));

`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
    // PREADY stuck low: ERROR after To ACCESS cycles, late PREADY ignored.
    x = mk(32'h4000_0400, 1'b1, HsizeWord, 32'h0, 32'h0, 0, 1'b0);
    issue_addr(x);
    @(posedge HCLK); #1;
    go_idle();
    PREADY = 1'b0;
    repeat (To + 1) @(posedge HCLK);
    @(negedge HCLK);
    chk("tmo_err1_hresp", 32'(HRESP), 32'd1);
    chk("tmo_err1_hreadyout", 32'(HREADYOUT), 32'd0);
    chk("tmo_err1_psel", 32'(PSEL), 32'd0);
    @(posedge HCLK); #1;
    PREADY = 1'b1;
    @(negedge HCLK);
    chk("tmo_err2_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("tmo_err2_penable", 32'(PENABLE), 32'd0);
    @(posedge HCLK); #1;
    PREADY = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
